// File: rtl/fractal_sync_arbiter.sv
// Fans N local fractal-sync requesters into one upstream master port with round-robin issue,
// and routes wake/error responses back to every port waiting on the matching barrier id.
module fractal_sync_arbiter #(
  parameter int unsigned N_PORTS    = 4,
  parameter int unsigned AGGR_WIDTH = 2,
  parameter int unsigned LVL_WIDTH  = 1,
  parameter int unsigned ID_WIDTH   = 2
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [N_PORTS-1:0]              slv_sync_i,
  input  logic [N_PORTS*AGGR_WIDTH-1:0]   slv_aggr_i,
  input  logic [N_PORTS*ID_WIDTH-1:0]     slv_id_req_i,
  output logic [N_PORTS-1:0]              slv_wake_o,
  output logic [N_PORTS*LVL_WIDTH-1:0]    slv_lvl_o,
  output logic [N_PORTS*ID_WIDTH-1:0]     slv_id_rsp_o,
  output logic [N_PORTS-1:0]              slv_error_o,
  output logic                            mst_sync_o,
  output logic [AGGR_WIDTH-1:0]           mst_aggr_o,
  output logic [ID_WIDTH-1:0]             mst_id_req_o,
  input  logic                            mst_wake_i,
  input  logic [LVL_WIDTH-1:0]            mst_lvl_i,
  input  logic [ID_WIDTH-1:0]             mst_id_rsp_i,
  input  logic                            mst_error_i
);

  localparam int unsigned PtrW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StPend,
    StWait
  } port_state_e;

  port_state_e           state_q [N_PORTS];
  logic [AGGR_WIDTH-1:0] aggr_q  [N_PORTS];
  logic [ID_WIDTH-1:0]   id_q    [N_PORTS];
  logic [PtrW-1:0]       rr_q;

  logic                          mst_sync_q;
  logic [AGGR_WIDTH-1:0]         mst_aggr_q;
  logic [ID_WIDTH-1:0]           mst_id_q;
  logic [N_PORTS-1:0]            wake_q;
  logic [N_PORTS-1:0]            error_q;
  logic [N_PORTS*LVL_WIDTH-1:0]  lvl_q;
  logic [N_PORTS*ID_WIDTH-1:0]   id_rsp_q;

  logic                 rsp_valid;
  logic [N_PORTS-1:0]   pend;
  logic [N_PORTS-1:0]   match;
  logic [N_PORTS-1:0]   viol;
  logic                 grant_valid;
  logic [PtrW-1:0]      grant_idx;
  logic [PtrW-1:0]      rr_next;
  int unsigned          cand;
  logic [PtrW-1:0]      cand_idx;

  assign rsp_valid = mst_wake_i | mst_error_i;

  // Only WAIT ports can match, so a port granted this cycle never sees this cycle's response.
  always_comb begin
    pend  = '0;
    match = '0;
    viol  = '0;
    for (int unsigned p = 0; p < N_PORTS; p++) begin
      pend[p]  = (state_q[p] == StPend);
      match[p] = rsp_valid && (state_q[p] == StWait) && (id_q[p] == mst_id_rsp_i);
      viol[p]  = slv_sync_i[p] && (state_q[p] != StIdle);
    end
  end

  // First PEND port at or after rr_q, wrapping.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    cand_idx    = '0;
    for (int unsigned i = 0; i < N_PORTS; i++) begin
      cand = 32'(rr_q) + i;
      if (cand >= N_PORTS) begin
        cand = cand - N_PORTS;
      end
      cand_idx = PtrW'(cand);
      if (!grant_valid && pend[cand_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = cand_idx;
      end
    end
  end

  assign rr_next = (grant_idx == PtrW'(N_PORTS - 1)) ? '0 : grant_idx + PtrW'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      mst_sync_q <= 1'b0;
      mst_aggr_q <= '0;
      mst_id_q   <= '0;
      wake_q     <= '0;
      error_q    <= '0;
      lvl_q      <= '0;
      id_rsp_q   <= '0;
      for (int unsigned p = 0; p < N_PORTS; p++) begin
        state_q[p] <= StIdle;
        aggr_q[p]  <= '0;
        id_q[p]    <= '0;
      end
    end else begin
      mst_sync_q <= grant_valid;
      if (grant_valid) begin
        mst_aggr_q <= aggr_q[grant_idx];
        mst_id_q   <= id_q[grant_idx];
        rr_q       <= rr_next;
      end
      for (int unsigned p = 0; p < N_PORTS; p++) begin
        wake_q[p]  <= match[p] & ~mst_error_i;
        // Violation and response error collapse into one pulse; response id wins below.
        error_q[p] <= (match[p] & mst_error_i) | viol[p];
        if (match[p]) begin
          lvl_q[p*LVL_WIDTH +: LVL_WIDTH]  <= mst_lvl_i;
          id_rsp_q[p*ID_WIDTH +: ID_WIDTH] <= mst_id_rsp_i;
        end else if (viol[p]) begin
          id_rsp_q[p*ID_WIDTH +: ID_WIDTH] <= slv_id_req_i[p*ID_WIDTH +: ID_WIDTH];
        end
        unique case (state_q[p])
          StIdle: begin
            if (slv_sync_i[p]) begin
              aggr_q[p]  <= slv_aggr_i[p*AGGR_WIDTH +: AGGR_WIDTH];
              id_q[p]    <= slv_id_req_i[p*ID_WIDTH +: ID_WIDTH];
              state_q[p] <= StPend;
            end
          end
          StPend: begin
            if (grant_valid && (grant_idx == PtrW'(p))) begin
              state_q[p] <= StWait;
            end
          end
          StWait: begin
            if (match[p]) begin
              state_q[p] <= StIdle;
            end
          end
          default: state_q[p] <= StIdle;
        endcase
      end
    end
  end

  assign mst_sync_o   = mst_sync_q;
  assign mst_aggr_o   = mst_aggr_q;
  assign mst_id_req_o = mst_id_q;
  assign slv_wake_o   = wake_q;
  assign slv_error_o  = error_q;
  assign slv_lvl_o    = lvl_q;
  assign slv_id_rsp_o = id_rsp_q;

  a_wake_error_excl: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (slv_wake_o & slv_error_o) == '0);

  a_rr_in_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
    32'(rr_q) < N_PORTS);

endmodule

// File: tb/tb_fractal_sync_arbiter.sv
// Scoreboard bench: stimulus pushes per-cycle expected outputs, a negedge monitor compares.
module tb_fractal_sync_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] slv_sync;
  logic [7:0] slv_aggr;
  logic [7:0] slv_id_req;
  logic [3:0] slv_wake;
  logic [3:0] slv_lvl;
  logic [7:0] slv_id_rsp;
  logic [3:0] slv_error;
  logic       mst_sync;
  logic [1:0] mst_aggr;
  logic [1:0] mst_id_req;
  logic       mst_wake;
  logic       mst_lvl;
  logic [1:0] mst_id_rsp;
  logic       mst_error;

  fractal_sync_arbiter #(
    .N_PORTS   (4),
    .AGGR_WIDTH(2),
    .LVL_WIDTH (1),
    .ID_WIDTH  (2)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .slv_sync_i  (slv_sync),
    .slv_aggr_i  (slv_aggr),
    .slv_id_req_i(slv_id_req),
    .slv_wake_o  (slv_wake),
    .slv_lvl_o   (slv_lvl),
    .slv_id_rsp_o(slv_id_rsp),
    .slv_error_o (slv_error),
    .mst_sync_o  (mst_sync),
    .mst_aggr_o  (mst_aggr),
    .mst_id_req_o(mst_id_req),
    .mst_wake_i  (mst_wake),
    .mst_lvl_i   (mst_lvl),
    .mst_id_rsp_i(mst_id_rsp),
    .mst_error_i (mst_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic       ms;
    logic [1:0] ma;
    logic [1:0] mi;
    logic [3:0] wk;
    logic [3:0] er;
    logic [3:0] lvl;
    logic [3:0] lchk;
    logic [7:0] idr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, req);
    end
  endtask

  function automatic int slot(input int c);
    exp_t n;
    int   pos;
    for (int i = 0; i < exp_q.size(); i++) if (exp_q[i].cyc == c) return i;
    n.cyc = c; n.ms = 0; n.ma = 0; n.mi = 0; n.wk = 0; n.er = 0;
    n.lvl = 0; n.lchk = 0; n.idr = 0;
    pos = exp_q.size();
    for (int i = exp_q.size() - 1; i >= 0; i--) if (exp_q[i].cyc > c) pos = i;
    exp_q.insert(pos, n);
    return pos;
  endfunction

  task automatic exp_mst(input int c, input logic [1:0] a, input logic [1:0] id);
    int   k;
    exp_t e;
    k = slot(c);
    e = exp_q[k];
    e.ms = 1'b1; e.ma = a; e.mi = id;
    exp_q[k] = e;
  endtask

  task automatic exp_pulse(input int c, input int p, input logic err, input logic lvl,
                           input logic [1:0] id, input logic lchk);
    int   k;
    exp_t e;
    k = slot(c);
    e = exp_q[k];
    if (err) e.er[p] = 1'b1;
    else     e.wk[p] = 1'b1;
    e.lvl[p]        = lvl;
    e.lchk[p]       = lchk;
    e.idr[p*2 +: 2] = id;
    exp_q[k] = e;
  endtask

  // Monitor
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst_n) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_event: expected cycle %0d not consumed at %0d", exp_q[0].cyc, cyc);
        void'(exp_q.pop_front());
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        mon_e = exp_q.pop_front();
        chk("mst_sync", 32'(mst_sync), 32'(mon_e.ms));
        if (mon_e.ms) begin
          chk("mst_aggr", 32'(mst_aggr), 32'(mon_e.ma));
          chk("mst_id_req", 32'(mst_id_req), 32'(mon_e.mi));
        end
        chk("slv_wake", 32'(slv_wake), 32'(mon_e.wk));
        chk("slv_error", 32'(slv_error), 32'(mon_e.er));
        for (int p = 0; p < 4; p++) begin
          if (mon_e.wk[p] || mon_e.er[p])
            chk($sformatf("slv_id_rsp[%0d]", p), 32'(slv_id_rsp[p*2 +: 2]),
                32'(mon_e.idr[p*2 +: 2]));
          if (mon_e.lchk[p])
            chk($sformatf("slv_lvl[%0d]", p), 32'(slv_lvl[p]), 32'(mon_e.lvl[p]));
        end
      end else begin
        chk("quiet_outputs", {23'd0, mst_sync, slv_wake, slv_error}, 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    slv_sync = '0; slv_aggr = '0; slv_id_req = '0;
    mst_wake = 1'b0; mst_error = 1'b0; mst_lvl = 1'b0; mst_id_rsp = '0;
  endtask

  task automatic step();
    tick();
    clear_inputs();
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic drive_sync(input int p, input logic [1:0] a, input logic [1:0] id);
    slv_sync[p]         = 1'b1;
    slv_aggr[p*2 +: 2]  = a;
    slv_id_req[p*2 +: 2] = id;
  endtask

  task automatic drive_rsp(input logic w, input logic e, input logic l, input logic [1:0] id);
    mst_wake = w; mst_error = e; mst_lvl = l; mst_id_rsp = id;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mst_sync"}, 32'(mst_sync), 32'd0);
    chk({tag, "_mst_aggr"}, 32'(mst_aggr), 32'd0);
    chk({tag, "_mst_id_req"}, 32'(mst_id_req), 32'd0);
    chk({tag, "_slv_wake"}, 32'(slv_wake), 32'd0);
    chk({tag, "_slv_error"}, 32'(slv_error), 32'd0);
    chk({tag, "_slv_lvl"}, 32'(slv_lvl), 32'd0);
    chk({tag, "_slv_id_rsp"}, 32'(slv_id_rsp), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int t;
  initial begin
    rst_n = 1'b0;
    clear_inputs();
    tick();
    tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Single request on port 1, then wake; rr ends at 2
    t = cyc;
    drive_sync(1, 2'b01, 2'd2); exp_mst(t + 2, 2'b01, 2'd2); step();
    wait_until(t + 5);
    drive_rsp(1, 0, 1, 2'd2); exp_pulse(t + 6, 1, 0, 1, 2'd2, 1); step();
    wait_until(t + 8);

    // Port 3 alone brings rr back to 0
    t = cyc;
    drive_sync(3, 2'b11, 2'd0); exp_mst(t + 2, 2'b11, 2'd0); step();
    wait_until(t + 4);
    drive_rsp(1, 0, 0, 2'd0); exp_pulse(t + 5, 3, 0, 0, 2'd0, 1); step();
    wait_until(t + 7);

    // Fairness: all four at once, granted 0,1,2,3 on consecutive cycles
    t = cyc;
    for (int p = 0; p < 4; p++) begin
      drive_sync(p, 2'(p), 2'(p));
      exp_mst(t + 2 + p, 2'(p), 2'(p));
    end
    step();
    for (int p = 0; p < 4; p++) begin
      wait_until(t + 6 + p);
      drive_rsp(1, 0, 1'(p), 2'(p)); exp_pulse(t + 7 + p, p, 0, 1'(p), 2'(p), 1); step();
    end
    wait_until(t + 12);

    // Shared barrier id 3 on ports 0 and 2; port 1 waits on id 1
    t = cyc;
    drive_sync(0, 2'd2, 2'd3); drive_sync(1, 2'd1, 2'd1); drive_sync(2, 2'd3, 2'd3);
    exp_mst(t + 2, 2'd2, 2'd3); exp_mst(t + 3, 2'd1, 2'd1); exp_mst(t + 4, 2'd3, 2'd3);
    step();
    wait_until(t + 5);
    drive_rsp(1, 0, 1, 2'd3);
    exp_pulse(t + 6, 0, 0, 1, 2'd3, 1); exp_pulse(t + 6, 2, 0, 1, 2'd3, 1);
    step();
    // Error beats wake; then an unmatched wake is dropped
    wait_until(t + 7);
    drive_rsp(1, 1, 0, 2'd1); exp_pulse(t + 8, 1, 1, 0, 2'd1, 1); step();
    wait_until(t + 9);
    drive_rsp(1, 0, 1, 2'd3); step();
    wait_until(t + 12);

    // Violation on waiting port 3 (rr=3 here)
    t = cyc;
    drive_sync(3, 2'd0, 2'd0); exp_mst(t + 2, 2'd0, 2'd0); step();
    wait_until(t + 3);
    drive_sync(3, 2'd1, 2'd2); exp_pulse(t + 4, 3, 1, 0, 2'd2, 0); step();
    wait_until(t + 6);
    drive_rsp(1, 0, 1, 2'd0); exp_pulse(t + 7, 3, 0, 1, 2'd0, 1); step();
    wait_until(t + 9);

    // Violation and response error on the same port in the same cycle (rr=0)
    t = cyc;
    drive_sync(2, 2'd1, 2'd1); exp_mst(t + 2, 2'd1, 2'd1); step();
    wait_until(t + 4);
    drive_sync(2, 2'd0, 2'd3); drive_rsp(0, 1, 1, 2'd1);
    exp_pulse(t + 5, 2, 1, 1, 2'd1, 1);
    step();
    wait_until(t + 7);

    // Port woken at t+5 re-syncs in that same cycle (rr=3)
    t = cyc;
    drive_sync(0, 2'd0, 2'd2); exp_mst(t + 2, 2'd0, 2'd2); step();
    wait_until(t + 4);
    drive_rsp(1, 0, 0, 2'd2); exp_pulse(t + 5, 0, 0, 0, 2'd2, 1); step();
    drive_sync(0, 2'd2, 2'd1); exp_mst(t + 7, 2'd2, 2'd1); step();
    wait_until(t + 8);
    drive_rsp(1, 0, 1, 2'd1); exp_pulse(t + 9, 0, 0, 1, 2'd1, 1); step();
    wait_until(t + 11);

    // Reset mid-flight: port 1 WAIT on id 2, port 0 PEND on id 1 with a grant pulse on mst
    t = cyc;
    drive_sync(0, 2'd1, 2'd1); drive_sync(1, 2'd2, 2'd2); step();
    tick();
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    tick();
    tick();
    rst_n = 1'b1;
    t = cyc;
    wait_until(t + 2);
    drive_rsp(1, 0, 1, 2'd2); step();
    drive_rsp(1, 0, 1, 2'd1); step();
    drive_rsp(0, 1, 1, 2'd2); step();
    wait_until(t + 6);

    // rr restarted at 0: port 1 is granted before port 2
    t = cyc;
    drive_sync(1, 2'd3, 2'd0); drive_sync(2, 2'd2, 2'd3);
    exp_mst(t + 2, 2'd3, 2'd0); exp_mst(t + 3, 2'd2, 2'd3);
    step();
    wait_until(t + 5);
    drive_rsp(1, 0, 0, 2'd0); exp_pulse(t + 6, 1, 0, 0, 2'd0, 1); step();
    drive_rsp(0, 1, 1, 2'd3); exp_pulse(t + 7, 2, 1, 1, 2'd3, 1); step();
    wait_until(t + 10);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fractal_sync_arbiter.md
# fractal_sync_arbiter

Shares one upstream fractal synchronization master port among N_PORTS local requesters, each presenting a fractal sync slave-side connection. Each port has a one-entry request buffer. A round-robin arbiter issues one upstream sync per cycle. Wake and error responses are routed back to every waiting port whose stored barrier id matches the response id. It sits between a cluster's local sync sources and the first synchronization tree node.

## Interface

Parameters:
- N_PORTS, 4, number of requester ports (≥2)
- AGGR_WIDTH, 2, width of aggr
- LVL_WIDTH, 1, width of lvl
- ID_WIDTH, 2, width of barrier id

Ports:
- clk_i  in  1  clock; single clock domain
- rst_ni  in  1  reset, asynchronous, active-low
- slv_sync_i  in  N_PORTS  per-port sync request pulse
- slv_aggr_i  in  N_PORTS×AGGR_WIDTH  per-port aggr
- slv_id_req_i  in  N_PORTS×ID_WIDTH  per-port barrier id
- slv_wake_o  out  N_PORTS  per-port wake pulse
- slv_lvl_o  out  N_PORTS×LVL_WIDTH  per-port response level
- slv_id_rsp_o  out  N_PORTS×ID_WIDTH  per-port response id
- slv_error_o  out  N_PORTS  per-port error pulse
- mst_sync_o  out  1  upstream sync pulse
- mst_aggr_o  out  AGGR_WIDTH  upstream aggr
- mst_id_req_o  out  ID_WIDTH  upstream id
- mst_wake_i  in  1  upstream wake
- mst_lvl_i  in  LVL_WIDTH  upstream level
- mst_id_rsp_i  in  ID_WIDTH  upstream response id
- mst_error_i  in  1  upstream error

## Operation

- Per-port FSM with states IDLE, PEND and WAIT. Each port stores aggr and id.
- Port in IDLE with slv_sync_i[p]=1:
  - captures aggr and id;
  - moves to PEND next cycle.
- Port in PEND or WAIT with slv_sync_i[p]=1 (protocol violation):
  - the new request is dropped;
  - slv_error_o[p] pulses one cycle later with slv_id_rsp_o[p]=offending id;
  - the port state is unchanged.
- Arbitration happens each cycle among PEND ports:
  - grant goes to the first PEND port at or after pointer rr_q, searching in increasing index with wrap;
  - the granted port moves to WAIT;
  - mst_sync_o, mst_aggr_o and mst_id_req_o are registered from its stored values;
  - rr_q becomes (granted+1) mod N_PORTS;
  - with no PEND port, mst_sync_o=0 and rr_q holds.
- Upstream response (mst_wake_i or mst_error_i high in cycle t):
  - only ports in WAIT at cycle t with stored id == mst_id_rsp_i are matched;
  - each matched port gets slv_wake_o (or slv_error_o) pulsed at t+1, with slv_lvl_o=mst_lvl_i and slv_id_rsp_o=mst_id_rsp_i;
  - each matched port returns to IDLE at t+1;
  - if wake and error are both high, error takes precedence (error pulse only);
  - a response with no matching port is silently dropped.
- Ports in PEND at cycle t (including one being granted at t) are never matched by a response at t.
- A violation error and a response error on the same port in the same cycle produce a single error pulse; slv_id_rsp_o carries the response id.
- slv_lvl_o and slv_id_rsp_o hold their last value when no pulse is present.

## Timing

- Reset clears everything:
  - all outputs 0;
  - all ports IDLE;
  - stored aggr/id 0;
  - rr_q=0.
- Request latency: slv_sync_i at t gives PEND at t+1 and mst_sync_o at t+2 at the earliest.
- Response latency: mst_wake_i/mst_error_i at t gives slv_wake_o/slv_error_o at t+1.
- All pulses are exactly one cycle wide. At most one mst_sync_o per cycle, so back-to-back grants on consecutive cycles are allowed.
- A port woken at t+1 may issue a new sync at t+1. It is captured normally because it is already IDLE.
- Under continuous contention, any PEND port is granted within N_PORTS cycles.
- Reset asserted mid-operation: pending and waiting requests are discarded; any later upstream response finds no match and is dropped.

## Test plan

- Single request: port 1 sync at t with aggr=2'b01, id=2 → mst_sync_o at t+2 with aggr=01, id=2. Then mst_wake_i at t+5 with lvl=1, id=2 → slv_wake_o[1] at t+6 with lvl=1, id_rsp=2; port 1 IDLE.
- Fairness: all 4 ports sync at t with rr_q=0 → mst_sync_o at t+2..t+5 carrying ports 0,1,2,3 in order; rr_q=0 after.
- Shared barrier: ports 0 and 2 both WAIT on id=3, port 1 WAIT on id=1; wake with id=3 → slv_wake_o[0] and slv_wake_o[2] pulse, port 1 stays WAIT.
- Violation: port 3 in WAIT (id=0) syncs with id=2 → slv_error_o[3] next cycle with id_rsp=2; port 3 still WAIT; a later wake with id=0 still delivers to it.
- Error precedence and no match: mst_wake_i=mst_error_i=1 with id=1 for port 1 in WAIT → only slv_error_o[1] pulses. A wake with id=3 while no port waits on 3 → no output activity.
- Reset mid-flight: assert rst_ni low with ports PEND and WAIT → all outputs 0 immediately; after release, a wake for the old id → no slv_wake_o.
